maze_solver_param: RTL

- Parametrised successor to the fixed 16x16 rat-in-maze solver.
- Performs a depth-first search over a 2^COORD_W x 2^COORD_W maze held in an external 1-bit-per-cell memory.
- Takes runtime start and goal coordinates and resumes the direction scan after a backtrack instead of restarting it.
- Stores the path on an internal stack and replays it, oldest move first, over a valid/ready stream on request.

---
 rtl/maze_solver_param_if.sv | 22 ++
 rtl/maze_solver_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/maze_solver_param_if.sv
// Playback stream carrying the solved path, one move code per beat.
// master drives the beats, slave accepts them.
interface maze_solver_param_if;
   logic       move_valid;
   logic       move_ready;
   logic [1:0] move;
   logic       move_last;

   modport master (
      output move_valid,
      output move,
      output move_last,
      input  move_ready
   );

   modport slave (
      input  move_valid,
      input  move,
      input  move_last,
      output move_ready
   );
endinterface

// File: rtl/maze_solver_param.sv
// Depth-first maze solver over an external 1-bit visited/wall memory,
// with resumable direction scan and in-order playback of the path.
module maze_solver_param #(
   parameter int COORD_W     = 4,
   parameter int STACK_DEPTH = 256
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               run,
   input  logic [COORD_W-1:0]                 start_x,
   input  logic [COORD_W-1:0]                 start_y,
   input  logic [COORD_W-1:0]                 goal_x,
   input  logic [COORD_W-1:0]                 goal_y,
   output logic [COORD_W-1:0]                 mem_x,
   output logic [COORD_W-1:0]                 mem_y,
   output logic                               mem_rd,
   input  logic                               mem_rd_data,
   output logic                               mem_wr,
   output logic                               busy,
   output logic                               done,
   output logic                               fail,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   path_len,
   maze_solver_param_if.master                mv
);

   localparam int PW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [PW-1:0]      ONE_P = 1;
   localparam logic [PW-1:0]      FULL  = PW'(STACK_DEPTH);
   localparam logic [COORD_W-1:0] ONE_C = 1;
   localparam logic [COORD_W-1:0] MAXC  = '1;

   typedef enum logic [3:0] {
      S_IDLE, S_MARK, S_PROBE, S_CHECK, S_ADV,
      S_BACK, S_SOLVED, S_PLAY, S_FAIL
   } state_t;

   state_t             state;
   logic [COORD_W-1:0] px, py, gx, gy;
   logic [1:0]         dir;
   logic [PW-1:0]      sp, idx;
   logic [1:0]         stack [STACK_DEPTH];

   logic [COORD_W-1:0] nx, ny, bx, by;
   logic [PW-1:0]      sp_m1;
   logic [1:0]         top;
   logic               oob, at_goal, cand_goal, is_last;

   // Coordinates wrap here; callers only use in-bounds results.
   function automatic logic [2*COORD_W-1:0] step(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input logic [1:0]         d
   );
      logic [COORD_W-1:0] sx, sy;
      sx = x;
      sy = y;
      unique case (d)
         2'd0:    sy = y + ONE_C;
         2'd1:    sx = x + ONE_C;
         2'd2:    sx = x - ONE_C;
         default: sy = y - ONE_C;
      endcase
      return {sx, sy};
   endfunction

   assign {nx, ny} = step(px, py, dir);
   assign sp_m1    = sp - ONE_P;
   assign top      = stack[sp_m1[AW-1:0]];
   assign {bx, by} = step(px, py, ~top);

   assign oob = (dir == 2'd0) ? (py == MAXC) :
                (dir == 2'd1) ? (px == MAXC) :
                (dir == 2'd2) ? (px == '0)   :
                                (py == '0);

   assign at_goal   = (px == gx) && (py == gy);
   assign cand_goal = (nx == gx) && (ny == gy);
   assign is_last   = (idx == sp_m1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         px    <= '0;
         py    <= '0;
         gx    <= '0;
         gy    <= '0;
         dir   <= '0;
         sp    <= '0;
         idx   <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_SOLVED, S_FAIL: begin
               if (start) begin
                  px    <= start_x;
                  py    <= start_y;
                  gx    <= goal_x;
                  gy    <= goal_y;
                  sp    <= '0;
                  dir   <= '0;
                  state <= S_MARK;
               end else if (state == S_SOLVED && run) begin
                  idx   <= '0;
                  state <= (sp == '0) ? S_IDLE : S_PLAY;
               end
            end
            S_MARK: state <= at_goal ? S_SOLVED : S_PROBE;
            S_PROBE: begin
               if (!oob)
                  state <= S_CHECK;
               else if (dir != 2'd3)
                  dir <= dir + 2'd1;
               else
                  state <= S_BACK;
            end
            S_CHECK: begin
               if (!mem_rd_data) begin
                  state <= S_ADV;
               end else if (dir != 2'd3) begin
                  dir   <= dir + 2'd1;
                  state <= S_PROBE;
               end else begin
                  state <= S_BACK;
               end
            end
            S_ADV: begin
               if (sp == FULL) begin
                  state <= S_FAIL;
               end else begin
                  stack[sp[AW-1:0]] <= dir;
                  sp    <= sp + ONE_P;
                  px    <= nx;
                  py    <= ny;
                  dir   <= '0;
                  state <= cand_goal ? S_SOLVED : S_PROBE;
               end
            end
            S_BACK: begin
               if (sp == '0) begin
                  state <= S_FAIL;
               end else begin
                  sp <= sp_m1;
                  px <= bx;
                  py <= by;
                  // A move of 3 exhausted its cell's scan: keep popping.
                  if (top != 2'd3) begin
                     dir   <= top + 2'd1;
                     state <= S_PROBE;
                  end
               end
            end
            S_PLAY: begin
               if (mv.move_ready) begin
                  if (is_last)
                     state <= S_IDLE;
                  else
                     idx <= idx + ONE_P;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_MARK)  || (state == S_PROBE) ||
                 (state == S_CHECK) || (state == S_ADV)   ||
                 (state == S_BACK);
   assign done     = (state == S_SOLVED) || (state == S_PLAY);
   assign fail     = (state == S_FAIL);
   assign path_len = sp;

   assign mem_rd = (state == S_PROBE) && !oob;
   assign mem_wr = (state == S_MARK) ||
                   ((state == S_ADV) && (sp != FULL));
   assign mem_x  = (state == S_MARK) ? px :
                   (mem_rd || (state == S_ADV)) ? nx : '0;
   assign mem_y  = (state == S_MARK) ? py :
                   (mem_rd || (state == S_ADV)) ? ny : '0;

   assign mv.move_valid = (state == S_PLAY);
   assign mv.move       = (state == S_PLAY) ? stack[idx[AW-1:0]] : 2'd0;
   assign mv.move_last  = (state == S_PLAY) && is_last;

endmodule
